outerprodrc_ctrl: RTL and testbench
===================================

Name: outerprodrc_ctrl

Overview:
- Sequencer for the unary outer-product GEMM array. Drives its enable/clear, and steps the operand fetch through K-tiles.
- Each tile runs one full unary bitstream window of 2^BITWIDTH cycles.
- Emits accumulate strobes aligned to the array's registered output, for the downstream binary accumulator.
- Sits between the tile-level scheduler (start/done handshake) and the array plus operand buffers.

Parameters:
- BITWIDTH, 8, operand bitwidth; stream window STREAMLEN = 2^BITWIDTH cycles per tile.
- TILEW, 8, width of tile count/index.
- PIPE_LAT, 2, cycles from array enable to valid array output (>=1).

Ports:
- iClk  input  1  clock, rising edge.
- iRst  input  1  reset, asynchronous, active-high.
- iStart  input  1  job start request; accepted only when idle.
- iNumTile  input  TILEW  number of K-tiles in job; sampled on accepted iStart.
- oBusy  output  1  high from accepted start until oDone cycle, inclusive.
- oEn  output  1  array enable (iEn of array).
- oClr  output  1  array clear (iClr of array).
- oTileIdx  output  TILEW  current tile index, for operand buffer address.
- oCycIdx  output  BITWIDTH  cycle index within stream window.
- oAccValid  output  1  array output valid this cycle.
- oAccFirst  output  1  with oAccValid: first valid output of job; accumulator loads instead of adds.
- oAccLast  output  1  with oAccValid: final valid output of job.
- oDone  output  1  one-cycle job-complete pulse.

Behaviour:
- Reset (async, iRst=1):
  - State IDLE; all counters 0.
  - All outputs 0.
  - Delay line flushed.
- Reset mid-job aborts immediately; no oDone is generated.
- IDLE:
  - If iStart=1 and iNumTile!=0: latch iNumTile, oTileIdx<=0, go to CLR.
  - If iStart=1 and iNumTile==0: go to DONE.
  - iStart while not IDLE is ignored, with no queueing.
- CLR (1 cycle):
  - oClr=1, oEn=0.
  - oCycIdx<=0, then go to RUN.
- RUN:
  - oEn=1, oClr=0; oCycIdx increments each cycle.
  - On oCycIdx==STREAMLEN-1:
    - If oTileIdx==NumTile-1, go to DRAIN.
    - Otherwise oTileIdx++, go to CLR.
  - oCycIdx wraps to 0.
- DRAIN:
  - Lasts exactly PIPE_LAT cycles, using a down-counter.
  - oEn=0; then go to DONE.
- DONE (1 cycle):
  - oDone=1, then go to IDLE.
  - iStart in the DONE cycle is ignored.
- oBusy is 1 in CLR, RUN, DRAIN and DONE.
- Strobes:
  - oAccValid = oEn delayed by exactly PIPE_LAT cycles through a shift register.
  - oAccFirst = (RUN, tile 0, cyc 0) delayed by PIPE_LAT.
  - oAccLast = (RUN, last tile, cyc STREAMLEN-1) delayed by PIPE_LAT.
  - oAccLast falls in the final DRAIN cycle, one cycle before oDone.
- Timing:
  - oDone is asserted 1 + N*(STREAMLEN+1) + PIPE_LAT cycles after the edge that accepts iStart, with N = NumTile.
  - Clear gaps between tiles produce oAccValid=0 bubbles.
- Counters use exact widths. Tile compare uses the latched NumTile, so iNumTile may change after acceptance.

Optional Feature:
- Macro OUTERPRODRC_CTRL_STALL_EN.
- When defined:
  - Adds port iStall (input, 1): operand buffers not ready.
  - While iStall=1 in RUN: oEn=0, oCycIdx and oTileIdx hold, state holds, and oAccValid shows the matching bubble PIPE_LAT later.
  - iStall is ignored in other states.
- When undefined:
  - There is no port, and RUN never pauses.

Decomposition:
- Shared outerprodrc.def gets:
  - The state encodings IDLE/CLR/RUN/DRAIN/DONE.
  - STREAMLEN derived from BITWIDTH.
  - The PIPE_LAT default matching the array latency.
- Natural sub-module: outerprodrc_ctrl_dly, a parameterised PIPE_LAT-deep, 3-bit-wide shift register carrying {valid, first, last}, with async active-high clear.

Test Plan:
- BITWIDTH=3, PIPE_LAT=2, iStart with iNumTile=2 -> expected response:
  - oClr at cycles 1 and 10.
  - oEn high for cycles 2-9 and 11-18.
  - oTileIdx 0 then 1.
  - oAccValid high for cycles 4-11 and 13-20.
  - oAccFirst at 4, oAccLast at 20, oDone at 21.
- iStart with iNumTile=0 -> oEn and oClr never asserted; oDone=1 one cycle after acceptance.
- iStart reasserted with iNumTile=5 during RUN of a 1-tile job -> ignored; exactly one oDone, and oTileIdx never exceeds 0.
- iRst pulsed mid-RUN, at tile 1 cyc 3 -> all outputs 0 asynchronously, no oDone; a new iStart then runs a clean job from tile 0.
- Back-to-back jobs: iStart held high -> a second job is accepted the cycle after oDone (IDLE), not in the DONE cycle.
- With STALL_EN, N=1, iStall high for 3 cycles at cyc 4 -> oCycIdx holds at 4; oDone delayed by exactly 3 cycles; oAccValid shows a 3-cycle gap.

Source files
------------

// File: rtl/outerprodrc_ctrl_pkg.sv
// Shared definitions for the outer-product GEMM array sequencer: state encodings,
// stream window length and default array pipeline latency.
package outerprodrc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } ctrlState_e;

    // Must track the registered-output latency of the unary array
    localparam int PIPE_LAT_DEF = 2;

    // Strobe delay line carries {valid, first, last}
    localparam int DLY_W = 3;

    function automatic int streamLen(input int bitWidth);
        return 1 << bitWidth;
    endfunction

endpackage

// File: rtl/outerprodrc_ctrl_dly.sv
// Fixed-depth shift register aligning the {valid, first, last} strobes with
// the array's registered output; async active-high clear.
module outerprodrc_ctrl_dly
    import outerprodrc_ctrl_pkg::*;
#(
    parameter int DEPTH = PIPE_LAT_DEF,
    parameter int WIDTH = DLY_W
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic [WIDTH-1:0] iD,
    output logic [WIDTH-1:0] oQ
);

    logic [WIDTH-1:0] stages [DEPTH];

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= iD;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign oQ = stages[DEPTH-1];

endmodule

// File: rtl/outerprodrc_ctrl.sv
// Sequencer for the unary outer-product GEMM array: clears, streams one full
// window per K-tile, drains the pipeline. Optional stall via OUTERPRODRC_CTRL_STALL_EN.
module outerprodrc_ctrl
    import outerprodrc_ctrl_pkg::*;
#(
    parameter int BITWIDTH = 8,
    parameter int TILEW    = 8,
    parameter int PIPE_LAT = PIPE_LAT_DEF
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iStart,
    input  logic [TILEW-1:0]    iNumTile,
`ifdef OUTERPRODRC_CTRL_STALL_EN
    input  logic                iStall,
`endif
    output logic                oBusy,
    output logic                oEn,
    output logic                oClr,
    output logic [TILEW-1:0]    oTileIdx,
    output logic [BITWIDTH-1:0] oCycIdx,
    output logic                oAccValid,
    output logic                oAccFirst,
    output logic                oAccLast,
    output logic                oDone
);

    localparam int STREAMLEN = streamLen(BITWIDTH);
    localparam logic [BITWIDTH-1:0] CYC_LAST = BITWIDTH'(STREAMLEN - 1);
    localparam int DRAIN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(PIPE_LAT - 1);

    ctrlState_e          state;
    ctrlState_e          nextState;
    logic [TILEW-1:0]    numTile;
    logic [TILEW-1:0]    tileIdx;
    logic [BITWIDTH-1:0] cycIdx;
    logic [DRAIN_W-1:0]  drainCnt;
    logic                stall;
    logic                lastCyc;
    logic                lastTile;
    logic                runEn;
    logic [DLY_W-1:0]    dlyIn;
    logic [DLY_W-1:0]    dlyOut;

`ifdef OUTERPRODRC_CTRL_STALL_EN
    assign stall = iStall;
`else
    assign stall = 1'b0;
`endif

    assign lastCyc  = (cycIdx == CYC_LAST);
    // Compare against the latched count so iNumTile may change mid-job
    assign lastTile = (tileIdx == (numTile - TILEW'(1)));

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE: begin
                if (iStart) begin
                    nextState = (iNumTile == '0) ? ST_DONE : ST_CLR;
                end
            end
            ST_CLR:   nextState = ST_RUN;
            ST_RUN: begin
                if (!stall && lastCyc) begin
                    nextState = lastTile ? ST_DRAIN : ST_CLR;
                end
            end
            ST_DRAIN: begin
                if (drainCnt == '0) begin
                    nextState = ST_DONE;
                end
            end
            ST_DONE:  nextState = ST_IDLE;
            default:  nextState = ST_IDLE;
        endcase
    end

    always_comb begin
        runEn = (state == ST_RUN) && !stall;
        oEn   = runEn;
        oClr  = (state == ST_CLR);
        oDone = (state == ST_DONE);
        oBusy = (state != ST_IDLE);
        dlyIn = {runEn,
                 runEn && (tileIdx == '0) && (cycIdx == '0),
                 runEn && lastTile && lastCyc};
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            numTile  <= '0;
            tileIdx  <= '0;
            cycIdx   <= '0;
            drainCnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (iStart && (iNumTile != '0)) begin
                        numTile <= iNumTile;
                        tileIdx <= '0;
                    end
                end
                ST_CLR: cycIdx <= '0;
                ST_RUN: begin
                    if (!stall) begin
                        cycIdx <= cycIdx + BITWIDTH'(1);
                        if (lastCyc && !lastTile) begin
                            tileIdx <= tileIdx + TILEW'(1);
                        end
                        if (lastCyc && lastTile) begin
                            drainCnt <= DRAIN_INIT;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drainCnt != '0) begin
                        drainCnt <= drainCnt - DRAIN_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    outerprodrc_ctrl_dly #(
        .DEPTH (PIPE_LAT),
        .WIDTH (DLY_W)
    ) uDly (
        .iClk (iClk),
        .iRst (iRst),
        .iD   (dlyIn),
        .oQ   (dlyOut)
    );

    assign oAccValid = dlyOut[2];
    assign oAccFirst = dlyOut[1];
    assign oAccLast  = dlyOut[0];
    assign oTileIdx  = tileIdx;
    assign oCycIdx   = cycIdx;

endmodule

// File: tb/tb_outerprodrc_ctrl.sv
// Directed self-checking bench for outerprodrc_ctrl at BITWIDTH=3, PIPE_LAT=2
// (9 cycles per tile including the clear); stall case under OUTERPRODRC_CTRL_STALL_EN.
module tb_outerprodrc_ctrl;

    logic       iClk;
    logic       iRst;
    logic       iStart;
    logic [7:0] iNumTile;
`ifdef OUTERPRODRC_CTRL_STALL_EN
    logic       iStall;
`endif
    logic       oBusy;
    logic       oEn;
    logic       oClr;
    logic [7:0] oTileIdx;
    logic [2:0] oCycIdx;
    logic       oAccValid;
    logic       oAccFirst;
    logic       oAccLast;
    logic       oDone;

    int testsRun    = 0;
    int testsFailed = 0;
    int doneCount;

    outerprodrc_ctrl #(
        .BITWIDTH (3),
        .TILEW    (8),
        .PIPE_LAT (2)
    ) dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .iStart    (iStart),
        .iNumTile  (iNumTile),
`ifdef OUTERPRODRC_CTRL_STALL_EN
        .iStall    (iStall),
`endif
        .oBusy     (oBusy),
        .oEn       (oEn),
        .oClr      (oClr),
        .oTileIdx  (oTileIdx),
        .oCycIdx   (oCycIdx),
        .oAccValid (oAccValid),
        .oAccFirst (oAccFirst),
        .oAccLast  (oAccLast),
        .oDone     (oDone)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Flags are {busy, en, clr, valid, first, last, done}; cycle 0 is the accepting cycle
    function automatic logic [6:0] expFlags(input int c, input int n);
        logic busy, en, clr, valid, first, last, done;
        busy  = (c >= 1) && (c <= 9*n + 3);
        en    = 1'b0;
        clr   = 1'b0;
        valid = 1'b0;
        for (int t = 0; t < n; t++) begin
            if (c == 1 + 9*t) clr = 1'b1;
            if (c >= 2 + 9*t && c <= 9 + 9*t) en = 1'b1;
            if (c >= 4 + 9*t && c <= 11 + 9*t) valid = 1'b1;
        end
        first = (c == 4);
        last  = (c == 9*n + 2);
        done  = (c == 9*n + 3);
        return {busy, en, clr, valid, first, last, done};
    endfunction

    function automatic logic [7:0] expTile(input int c, input int n);
        int t;
        t = (c - 1) / 9;
        if (t > n - 1) t = n - 1;
        return 8'(t);
    endfunction

    function automatic logic [2:0] expCyc(input int c);
        if ((c - 1) % 9 == 0) return 3'd0;
        return 3'((c - 2) % 9);
    endfunction

    task automatic applyStimulus(input logic start, input int num);
        iStart   = start;
        iNumTile = 8'(num);
    endtask

    task automatic checkOutput(input string tag, input logic [6:0] eFlags,
                               input logic [7:0] eTile, input logic [2:0] eCyc,
                               input bit chkTile, input bit chkCyc);
        logic [6:0] obs;
        obs = {oBusy, oEn, oClr, oAccValid, oAccFirst, oAccLast, oDone};
        testsRun++;
        assert (obs === eFlags) else begin
            testsFailed++;
            $error("[TB] FAIL %s flags: observed %b expected %b", tag, obs, eFlags);
        end
        if (chkTile) begin
            testsRun++;
            assert (oTileIdx === eTile) else begin
                testsFailed++;
                $error("[TB] FAIL %s tile: observed %0d expected %0d", tag, oTileIdx, eTile);
            end
        end
        if (chkCyc) begin
            testsRun++;
            assert (oCycIdx === eCyc) else begin
                testsFailed++;
                $error("[TB] FAIL %s cyc: observed %0d expected %0d", tag, oCycIdx, eCyc);
            end
        end
    endtask

    task automatic runStdJob(input int n, input string name);
        logic [6:0] f;
        applyStimulus(1'b1, n);
        for (int c = 1; c <= 9*n + 5; c++) begin
            @(negedge iClk);
            if (c == 1) applyStimulus(1'b0, n);
            f = expFlags(c, n);
            checkOutput($sformatf("%s c%0d", name, c), f, expTile(c, n), expCyc(c),
                        f[6], f[5] | f[4]);
        end
    endtask

    initial begin
        logic [6:0] f;
        iRst = 1'b1;
        applyStimulus(1'b0, 0);
`ifdef OUTERPRODRC_CTRL_STALL_EN
        iStall = 1'b0;
`endif
        @(negedge iClk);
        @(negedge iClk);
        checkOutput("reset", 7'b0, 8'd0, 3'd0, 1'b1, 1'b1);
        iRst = 1'b0;
        @(negedge iClk);
        checkOutput("idle", 7'b0, 8'd0, 3'd0, 1'b1, 1'b1);

        runStdJob(2, "job2");

        // Zero tiles: straight to DONE
        applyStimulus(1'b1, 0);
        @(negedge iClk);
        applyStimulus(1'b0, 0);
        checkOutput("zero c1", 7'b1000001, 8'd0, 3'd0, 1'b0, 1'b0);
        for (int c = 2; c <= 4; c++) begin
            @(negedge iClk);
            checkOutput($sformatf("zero c%0d", c), 7'b0, 8'd0, 3'd0, 1'b0, 1'b0);
        end

        // Restart requests during RUN must be ignored
        doneCount = 0;
        applyStimulus(1'b1, 1);
        for (int c = 1; c <= 20; c++) begin
            @(negedge iClk);
            if (c == 1) applyStimulus(1'b0, 1);
            if (c == 5) applyStimulus(1'b1, 5);
            if (c == 8) applyStimulus(1'b0, 1);
            if (oDone) doneCount++;
            f = expFlags(c, 1);
            checkOutput($sformatf("ignore c%0d", c), f, 8'd0, expCyc(c), 1'b1, f[5] | f[4]);
        end
        testsRun++;
        assert (doneCount == 1) else begin
            testsFailed++;
            $error("[TB] FAIL ignore doneCount: observed %0d expected 1", doneCount);
        end

        // Async reset mid-RUN at tile 1 cyc 3
        applyStimulus(1'b1, 2);
        for (int c = 1; c <= 14; c++) begin
            @(negedge iClk);
            if (c == 1) applyStimulus(1'b0, 2);
            f = expFlags(c, 2);
            checkOutput($sformatf("abort c%0d", c), f, expTile(c, 2), expCyc(c),
                        1'b1, f[5] | f[4]);
        end
        iRst = 1'b1;
        #1;
        checkOutput("abort async", 7'b0, 8'd0, 3'd0, 1'b1, 1'b1);
        @(negedge iClk);
        iRst = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge iClk);
            checkOutput($sformatf("abort quiet c%0d", c), 7'b0, 8'd0, 3'd0, 1'b1, 1'b1);
        end
        runStdJob(1, "after abort");

        // Back-to-back with iStart held: second accept is the cycle after DONE
        applyStimulus(1'b1, 1);
        for (int c = 1; c <= 27; c++) begin
            @(negedge iClk);
            if (c == 14) applyStimulus(1'b0, 1);
            f = (c <= 12) ? expFlags(c, 1) : expFlags(c - 13, 1);
            checkOutput($sformatf("b2b c%0d", c), f, 8'd0,
                        (c <= 12) ? expCyc(c) : expCyc(c - 13), f[6], f[5] | f[4]);
        end

`ifdef OUTERPRODRC_CTRL_STALL_EN
        // Stall 3 cycles at cyc 4 of a 1-tile job
        applyStimulus(1'b1, 1);
        for (int c = 1; c <= 17; c++) begin
            logic en, clr, valid;
            logic [2:0] cyc;
            @(negedge iClk);
            if (c == 1) applyStimulus(1'b0, 1);
            if (c == 6) iStall = 1'b1;
            if (c == 9) iStall = 1'b0;
            en    = (c >= 2 && c <= 5) || (c >= 9 && c <= 12);
            clr   = (c == 1);
            valid = (c >= 4 && c <= 7) || (c >= 11 && c <= 14);
            if (c >= 2 && c <= 5)      cyc = 3'(c - 2);
            else if (c >= 6 && c <= 8) cyc = 3'd4;
            else if (c >= 9)           cyc = 3'(c - 5);
            else                       cyc = 3'd0;
            f = {(c >= 1 && c <= 15), en, clr, valid, (c == 4), (c == 14), (c == 15)};
            checkOutput($sformatf("stall c%0d", c), f, 8'd0, cyc, f[6], c <= 12);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
